// File: rtl/ticket_queue_driver.sv
// Ticket queue driver: two synchronized, edge-detected push buttons issue and call tickets.
// It produces the issued/serving numbers for the queue comparator, plus occupancy and call status.
module ticket_queue_driver #(
    parameter int unsigned WIDTH       = 2,
    parameter int unsigned CALL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_take_btn,
    input  logic             i_next_btn,
    output logic [WIDTH-1:0] o_issued_no,
    output logic [WIDTH-1:0] o_serving_no,
    output logic [WIDTH:0]   o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_calling,
    output logic             o_take_reject
);

    localparam int unsigned    TW    = (CALL_CYCLES < 2) ? 1 : $clog2(CALL_CYCLES + 1);
    localparam logic [WIDTH:0] DEPTH = {1'b0, {WIDTH{1'b1}}};
    localparam logic [TW-1:0]  TLOAD = TW'(CALL_CYCLES);

    typedef enum logic [1:0] {StIdle, StWaiting, StCalling} state_t;

    logic           r_take_s1, r_take_s2, r_take_prev;
    logic           r_next_s1, r_next_s2, r_next_prev;
    logic [1:0]     r_warm;
    state_t         r_state;
    logic [TW-1:0]  r_timer;
    logic [WIDTH-1:0] r_issued_no, r_serving_no;
    logic [WIDTH:0] r_count;
    logic           r_calling, r_take_reject;

    logic           w_warm;
    logic           w_take_ev, w_next_ev;
    logic           w_take_ok, w_take_rej, w_next_ok;
    logic [WIDTH:0] w_count_nxt;

    // The "previous" flops stay high until the synchronizers have flushed their
    // reset contents, so a button held through reset release raises no event.
    assign w_warm = r_warm[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_take_s1   <= 1'b0;
            r_take_s2   <= 1'b0;
            r_take_prev <= 1'b1;
            r_next_s1   <= 1'b0;
            r_next_s2   <= 1'b0;
            r_next_prev <= 1'b1;
            r_warm      <= 2'd0;
        end else begin
            r_take_s1   <= i_take_btn;
            r_take_s2   <= r_take_s1;
            r_take_prev <= w_warm ? r_take_s2 : 1'b1;
            r_next_s1   <= i_next_btn;
            r_next_s2   <= r_next_s1;
            r_next_prev <= w_warm ? r_next_s2 : 1'b1;
            if (!w_warm) begin
                r_warm <= r_warm + 2'd1;
            end
        end
    end

    assign w_take_ev  = r_take_s2 & ~r_take_prev;
    assign w_next_ev  = r_next_s2 & ~r_next_prev;
    assign w_take_ok  = w_take_ev & (r_count < DEPTH);
    assign w_take_rej = w_take_ev & (r_count == DEPTH);
    assign w_next_ok  = w_next_ev & (r_count != '0) & (r_state != StCalling);

    always_comb begin
        w_count_nxt = r_count;
        if (w_take_ok && !w_next_ok) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_take_ok && w_next_ok) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_timer       <= '0;
            r_issued_no   <= '0;
            r_serving_no  <= '0;
            r_count       <= '0;
            r_calling     <= 1'b0;
            r_take_reject <= 1'b0;
        end else begin
            r_count       <= w_count_nxt;
            r_take_reject <= w_take_rej;
            if (w_take_ok) begin
                r_issued_no <= r_issued_no + 1'b1;
            end
            if (w_next_ok) begin
                r_serving_no <= r_serving_no + 1'b1;
                r_state      <= StCalling;
                r_calling    <= 1'b1;
                r_timer      <= TLOAD;
            end else if (r_state == StCalling) begin
                if (r_timer == TW'(1)) begin
                    r_calling <= 1'b0;
                    r_state   <= (w_count_nxt != '0) ? StWaiting : StIdle;
                end else begin
                    r_timer <= r_timer - 1'b1;
                end
            end else begin
                r_state <= (w_count_nxt != '0) ? StWaiting : StIdle;
            end
        end
    end

    assign o_issued_no   = r_issued_no;
    assign o_serving_no  = r_serving_no;
    assign o_count       = r_count;
    assign o_full        = (r_count == DEPTH);
    assign o_empty       = (r_count == '0);
    assign o_calling     = r_calling;
    assign o_take_reject = r_take_reject;

endmodule

// File: tb/tb_ticket_queue_driver.sv
// Self-checking bench for ticket_queue_driver: directed scenarios plus randomized button
// activity compared against a ticket-count reference model.
module tb_ticket_queue_driver;

    localparam int unsigned W     = 2;
    localparam int          C     = 4;
    localparam int          DEPTH = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         take = 1'b0;
    logic         nxt = 1'b0;
    logic [W-1:0] issued_no, serving_no;
    logic [W:0]   count;
    logic         full, empty, calling, take_reject;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ticket_queue_driver #(.WIDTH(W), .CALL_CYCLES(C)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_take_btn   (take),
        .i_next_btn   (nxt),
        .o_issued_no  (issued_no),
        .o_serving_no (serving_no),
        .o_count      (count),
        .o_full       (full),
        .o_empty      (empty),
        .o_calling    (calling),
        .o_take_reject(take_reject)
    );

    // Reference model: total tickets issued/served since reset, edge index of the last
    // accepted call, and the last three sampled button levels (pre-reset counts as high).
    int   m_n, m_iss, m_srv, m_acc, m_pre_count;
    logic m_rej;
    logic t_h1, t_h2, t_h3, n_h1, n_h2, n_h3;
    logic m_tev, m_nev, m_take_ok, m_next_ok, m_pre_calling;

    always_comb begin
        m_pre_count   = m_iss - m_srv;
        m_tev         = t_h2 & ~t_h3;
        m_nev         = n_h2 & ~n_h3;
        m_take_ok     = m_tev && (m_pre_count < DEPTH);
        m_pre_calling = (m_n + 1 > m_acc) && (m_n + 1 <= m_acc + C);
        m_next_ok     = m_nev && (m_pre_count > 0) && !m_pre_calling;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n <= 0; m_iss <= 0; m_srv <= 0; m_acc <= -1000; m_rej <= 1'b0;
            t_h1 <= 1'b1; t_h2 <= 1'b1; t_h3 <= 1'b1;
            n_h1 <= 1'b1; n_h2 <= 1'b1; n_h3 <= 1'b1;
        end else begin
            m_n   <= m_n + 1;
            m_iss <= m_iss + (m_take_ok ? 1 : 0);
            m_srv <= m_srv + (m_next_ok ? 1 : 0);
            if (m_next_ok) m_acc <= m_n + 1;
            m_rej <= m_tev && !m_take_ok;
            t_h1 <= take; t_h2 <= t_h1; t_h3 <= t_h2;
            n_h1 <= nxt;  n_h2 <= n_h1; n_h3 <= n_h2;
        end
    end

    // Advance to the next falling edge and assert the count invariant.
    task automatic tick();
        logic [W-1:0] d;
        @(negedge clk);
        d = issued_no - serving_no;
        n_checks++;
        assert (count === {1'b0, d}) n_pass++;
        else $display("FAIL invariant: count=%0d issued=%0d serving=%0d", count, issued_no,
                      serving_no);
    endtask

    task automatic do_reset();
        take = 1'b0; nxt = 1'b0; rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Hold the chosen buttons for two samples, release, and let the event land.
    task automatic press(input logic t, input logic n, output int rej);
        rej = 0;
        take = t; nxt = n;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin take = 1'b0; nxt = 1'b0; end
            tick();
            if (take_reject) rej++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        repeat (10) tick();
        n_checks++;
        if ({issued_no, serving_no, count, empty, full, calling, take_reject} !==
            {2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_state: got iss=%0d srv=%0d cnt=%0d e=%b f=%b c=%b r=%b",
                     issued_no, serving_no, count, empty, full, calling, take_reject);
        else n_pass++;
    endtask

    task automatic test_latency();
        do_reset();
        take = 1'b1;
        tick(); tick();
        n_checks++;
        if (issued_no !== 2'd0) $display("FAIL latency_early: issued=%0d want 0", issued_no);
        else n_pass++;
        tick();
        n_checks++;
        if ({issued_no, count, empty} !== {2'd1, 3'd1, 1'b0})
            $display("FAIL latency_e3: iss=%0d cnt=%0d empty=%b want 1 1 0", issued_no, count,
                     empty);
        else n_pass++;
        tick(); tick();
        take = 1'b0;
        repeat (5) tick();
        n_checks++;
        if ({issued_no, count} !== {2'd1, 3'd1})
            $display("FAIL latency_single: iss=%0d cnt=%0d want 1 1", issued_no, count);
        else n_pass++;
        // Button held high across reset release.
        take = 1'b1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        take = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({issued_no, count} !== {2'd0, 3'd0})
            $display("FAIL held_through_reset: iss=%0d cnt=%0d want 0 0", issued_no, count);
        else n_pass++;
    endtask

    task automatic test_fill();
        int rej, tot;
        do_reset();
        tot = 0;
        for (int i = 0; i < 3; i++) begin press(1'b1, 1'b0, rej); tot += rej; end
        n_checks++;
        if ({issued_no, count, full, tot[1:0]} !== {2'd3, 3'd3, 1'b1, 2'd0})
            $display("FAIL fill: iss=%0d cnt=%0d full=%b rej=%0d want 3 3 1 0", issued_no,
                     count, full, tot);
        else n_pass++;
        press(1'b1, 1'b0, rej);
        n_checks++;
        if ({rej[1:0], issued_no, count} !== {2'd1, 2'd3, 3'd3})
            $display("FAIL overflow: rej=%0d iss=%0d cnt=%0d want 1 3 3", rej, issued_no, count);
        else n_pass++;
    endtask

    task automatic test_call();
        int rej, cal;
        do_reset();
        press(1'b1, 1'b0, rej);
        press(1'b1, 1'b0, rej);
        nxt = 1'b1;
        tick(); tick();
        nxt = 1'b0;
        tick();
        n_checks++;
        if ({serving_no, count, calling} !== {2'd1, 3'd1, 1'b1})
            $display("FAIL call_accept: srv=%0d cnt=%0d calling=%b want 1 1 1", serving_no,
                     count, calling);
        else n_pass++;
        cal = 1;
        nxt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) nxt = 1'b0;
            tick();
            if (calling) cal++;
        end
        n_checks++;
        if (cal !== C) $display("FAIL call_length: calling cycles=%0d want %0d", cal, C);
        else n_pass++;
        n_checks++;
        if ({serving_no, count, calling, empty} !== {2'd1, 3'd1, 1'b0, 1'b0})
            $display("FAIL call_drop: srv=%0d cnt=%0d calling=%b empty=%b want 1 1 0 0",
                     serving_no, count, calling, empty);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int rej;
        do_reset();
        press(1'b1, 1'b0, rej);
        nxt = 1'b1;
        tick(); tick();
        nxt = 1'b0;
        tick();
        n_checks++;
        if (calling !== 1'b1) $display("FAIL async_pre: calling=%b want 1", calling);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({issued_no, serving_no, count, empty, full, calling, take_reject} !==
            {2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL async_reset: iss=%0d srv=%0d cnt=%0d e=%b f=%b c=%b", issued_no,
                     serving_no, count, empty, full, calling);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int rej;
        do_reset();
        press(1'b1, 1'b0, rej);
        press(1'b1, 1'b1, rej);
        n_checks++;
        if ({issued_no, serving_no, count, rej[0]} !== {2'd2, 2'd1, 3'd1, 1'b0})
            $display("FAIL simul_mid: iss=%0d srv=%0d cnt=%0d rej=%0d want 2 1 1 0", issued_no,
                     serving_no, count, rej);
        else n_pass++;
        press(1'b1, 1'b0, rej);
        press(1'b1, 1'b0, rej);
        repeat (4) tick();
        n_checks++;
        if ({full, calling} !== {1'b1, 1'b0})
            $display("FAIL simul_prefull: full=%b calling=%b want 1 0", full, calling);
        else n_pass++;
        press(1'b1, 1'b1, rej);
        n_checks++;
        if ({rej[1:0], count, issued_no, serving_no} !== {2'd1, 3'd2, 2'd0, 2'd2})
            $display("FAIL simul_full: rej=%0d cnt=%0d iss=%0d srv=%0d want 1 2 0 2", rej,
                     count, issued_no, serving_no);
        else n_pass++;
        // Simultaneous press when empty: next dropped, take accepted.
        do_reset();
        press(1'b1, 1'b1, rej);
        n_checks++;
        if ({issued_no, serving_no, count, calling} !== {2'd1, 2'd0, 3'd1, 1'b0})
            $display("FAIL simul_empty: iss=%0d srv=%0d cnt=%0d calling=%b want 1 0 1 0",
                     issued_no, serving_no, count, calling);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int rej;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            press(1'b1, 1'b0, rej);
            press(1'b0, 1'b1, rej);
            repeat (4) tick();
        end
        n_checks++;
        if ({issued_no, serving_no, count, empty, full} !== {2'd2, 2'd2, 3'd0, 1'b1, 1'b0})
            $display("FAIL wrap: iss=%0d srv=%0d cnt=%0d empty=%b full=%b want 2 2 0 1 0",
                     issued_no, serving_no, count, empty, full);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] e_iss, e_srv;
        logic [W:0]   e_cnt;
        logic         e_cal;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) take = ~take;
            if ($urandom_range(0, 4) == 0) nxt = ~nxt;
            tick();
            e_iss = W'(m_iss);
            e_srv = W'(m_srv);
            e_cnt = (W + 1)'(m_iss - m_srv);
            e_cal = (m_n >= m_acc) && (m_n < m_acc + C);
            n_checks++;
            if ({issued_no, serving_no, count, full, empty, calling, take_reject} !==
                {e_iss, e_srv, e_cnt, e_cnt == 3'(DEPTH), e_cnt == 3'd0, e_cal, m_rej})
                $display("FAIL random[%0d]: got iss=%0d srv=%0d cnt=%0d c=%b r=%b want %0d %0d %0d %b %b",
                         i, issued_no, serving_no, count, calling, take_reject, e_iss, e_srv,
                         e_cnt, e_cal, m_rej);
            else n_pass++;
        end
        take = 1'b0; nxt = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_call();
        test_async_reset();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
